pulse_stretcher: RTL and testbench

- Converts single-cycle pulses (as produced by the single pulser after synchronisation/debounce) back into visible fixed-width levels for LED/actuator drive.
- Pulses arriving while an output pulse is active are queued in a saturating pending counter and replayed in order, separated by a minimum low gap.
- Sits downstream of the single pulser and upstream of board outputs.

---
 rtl/pulse_stretcher.sv | 113 +++++++++++
 tb/tb_pulse_stretcher.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle pulses into fixed-width levels, queueing overlaps
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sp_i,
  input  logic              clr_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PEND_W-1:0] r_pend, w_pend_nxt;
  logic              r_level, r_busy, r_ovf;
  logic              w_ovf_set, w_level_nxt, w_busy_nxt, w_ovf_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sp_i) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      S_HIGH: begin
        if (r_cnt == HIGH_LAST) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (sp_i) begin
          if (r_pend != PEND_MAX) w_pend_nxt = r_pend + 1'b1;
          else                    w_ovf_set  = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          // A pulse arriving on the exit edge replaces the one being consumed.
          if (r_pend != '0) begin
            w_state_nxt = S_HIGH;
            if (!sp_i) w_pend_nxt = r_pend - 1'b1;
          end else if (sp_i) begin
            w_state_nxt = S_HIGH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (sp_i) begin
            if (r_pend != PEND_MAX) w_pend_nxt = r_pend + 1'b1;
            else                    w_ovf_set  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_level_nxt = (w_state_nxt == S_HIGH);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    if (w_ovf_set)  w_ovf_nxt = 1'b1;
    else if (clr_i) w_ovf_nxt = 1'b0;
    else            w_ovf_nxt = r_ovf;
  end

  assign level_o = r_level;
  assign busy_o  = r_busy;
  assign pend_o  = r_pend;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sp_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       level_o, busy_o, ovf_o;
  logic [1:0] pend_o;

  int n_chk  = 0;
  int n_fail = 0;
  int rises;
  logic prev_level;

  pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .sp_i(sp_i), .clr_i(clr_i),
    .level_o(level_o), .busy_o(busy_o), .pend_o(pend_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int lv, input int bz, input int pd);
    chk({tag, ".level"}, int'(level_o), lv);
    chk({tag, ".busy"},  int'(busy_o),  bz);
    chk({tag, ".pend"},  int'(pend_o),  pd);
  endtask

  initial begin
    // Reset state, held through one edge
    #12;
    chk_out("reset", 0, 0, 0);
    chk("reset.ovf", int'(ovf_o), 0);
    rst = 1'b1;
    tick();
    chk_out("idle", 0, 0, 0);

    // Single pulse: 4 cycles high, 6 cycles busy
    sp_i = 1'b1; tick(); sp_i = 1'b0;
    chk_out("single_k0", 1, 1, 0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_out($sformatf("single_k%0d", e), 1, 1, 0);
    end
    tick(); chk_out("single_k4", 0, 1, 0);
    tick(); chk_out("single_k5", 0, 1, 0);
    tick(); chk_out("single_k6", 0, 0, 0);

    // Burst of three: rises at k, k+6, k+12; idle at k+18
    sp_i = 1'b1;
    tick(); chk_out("burst_k0", 1, 1, 0);
    tick(); chk_out("burst_k1", 1, 1, 1);
    tick(); chk_out("burst_k2", 1, 1, 2);
    sp_i = 1'b0;
    for (int e = 3; e <= 18; e++) begin
      tick();
      chk_out($sformatf("burst_k%0d", e),
              (e < 18 && (e % 6) < 4) ? 1 : 0,
              (e < 18) ? 1 : 0,
              (e < 6) ? 2 : (e < 12) ? 1 : 0);
    end

    // Overflow: five pulses saturate pend at 3 and set ovf
    sp_i = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    chk("ovf_k3.pend", int'(pend_o), 3);
    chk("ovf_k3.ovf", int'(ovf_o), 0);
    tick();
    sp_i = 1'b0;
    chk("ovf_k4.pend", int'(pend_o), 3);
    chk("ovf_k4.ovf", int'(ovf_o), 1);
    rises = 1;
    prev_level = level_o;
    for (int e = 5; e <= 24; e++) begin
      tick();
      if (level_o && !prev_level) rises++;
      prev_level = level_o;
    end
    chk("ovf.rises", rises, 4);
    chk_out("ovf_k24", 0, 0, 0);
    chk("ovf.sticky", int'(ovf_o), 1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("ovf.cleared", int'(ovf_o), 0);

    // Pulse exactly on the GAP exit edge with nothing pending
    sp_i = 1'b1; tick(); sp_i = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    chk_out("gapx_k5", 0, 1, 0);
    sp_i = 1'b1; tick(); sp_i = 1'b0;
    chk_out("gapx_k6", 1, 1, 0);
    for (int e = 7; e <= 11; e++) tick();
    chk_out("gapx_k11", 0, 1, 0);
    tick();
    chk_out("gapx_k12", 0, 0, 0);

    // Clear and overflow on the same edge: set wins
    sp_i = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    chk("clrovf_k3.pend", int'(pend_o), 3);
    clr_i = 1'b1; tick(); clr_i = 1'b0; sp_i = 1'b0;
    chk("clrovf.ovf", int'(ovf_o), 1);

    // Async reset mid-pulse with two queued
    rst = 1'b0; #3; rst = 1'b1;
    chk_out("rst2", 0, 0, 0);
    chk("rst2.ovf", int'(ovf_o), 0);
    sp_i = 1'b1;
    tick(); tick(); tick();
    sp_i = 1'b0;
    chk_out("arst_pre", 1, 1, 2);
    #1;
    rst = 1'b0;
    #1;
    chk_out("arst_now", 0, 0, 0);
    rst = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("arst_after%0d.level", e), int'(level_o), 0);
    end
    chk("arst_after.busy", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
